// File: rtl/rca_bcd_7seg_seq.sv
// Sequential W-bit adder with bit-serial double-dabble conversion of X, Y and the sum
// into three 7-segment banks that are refreshed together when the conversion finishes.
module rca_bcd_7seg_seq #(
   parameter int W      = 8,
   parameter int DIGITS = 3,
   parameter int LZB    = 1,
   parameter int SEG_AL = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [W-1:0]          X,
   input  logic [W-1:0]          Y,
   input  logic                  C_IN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [W:0]            SUM_BIN,
   output logic                  C_OUT,
   output logic [7*DIGITS-1:0]   X7,
   output logic [7*DIGITS-1:0]   Y7,
   output logic [7*DIGITS-1:0]   S7
);

   localparam int BW = 4 * DIGITS;
   localparam int SW = BW + W + 1;
   localparam int CW = $clog2(W + 1);

   if ((64'(10) ** DIGITS) <= ((64'(1) << (W + 1)) - 64'(1))) begin : g_bad_digits
      $error("rca_bcd_7seg_seq: DIGITS too small for a W+1 bit sum");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FIN} state_t;

   function automatic logic [6:0] seg_digit(input logic [3:0] d, input logic blank);
      logic [6:0] s;
      if (blank) begin
         s = 7'b1111111;
      end else begin
         case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
         endcase
      end
      return (SEG_AL != 0) ? s : ~s;
   endfunction

   // Walk from the top digit down so blanking stops at the first non-zero digit.
   function automatic logic [7*DIGITS-1:0] encode(input logic [BW-1:0] bcd);
      logic [7*DIGITS-1:0] o;
      logic                lead;
      logic [3:0]          d;
      logic                blank;
      o    = '0;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d     = bcd[4*i +: 4];
         blank = (LZB != 0) && (i != 0) && lead && (d == 4'd0);
         if (d != 4'd0) begin
            lead = 1'b0;
         end else begin
            lead = lead;
         end
         o[7*i +: 7] = seg_digit(d, blank);
      end
      return o;
   endfunction

   state_t          r_state;
   logic [1:0]      r_sel;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_x;
   logic [W-1:0]    r_y;
   logic [W:0]      r_sum;
   logic [SW-1:0]   r_sh;
   logic [BW-1:0]   r_stage_x;
   logic [BW-1:0]   r_stage_y;

   logic [W:0]      w_val;
   logic [SW-1:0]   w_adj;
   logic [SW-1:0]   w_next;
   logic [BW-1:0]   w_next_bcd;

   // Operand selection and one double-dabble step (add-3 correction then shift).
   always_comb begin
      case (r_sel)
         2'd0:    w_val = {1'b0, r_x};
         2'd1:    w_val = {1'b0, r_y};
         default: w_val = r_sum;
      endcase
      w_adj = r_sh;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_sh[W+1+4*i +: 4] >= 4'd5) begin
            w_adj[W+1+4*i +: 4] = r_sh[W+1+4*i +: 4] + 4'd3;
         end else begin
            w_adj[W+1+4*i +: 4] = r_sh[W+1+4*i +: 4];
         end
      end
      w_next     = {w_adj[SW-2:0], 1'b0};
      w_next_bcd = w_next[SW-1:W+1];
   end

   // Control FSM, datapath and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_sel     <= 2'd0;
         r_cnt     <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_sum     <= '0;
         r_sh      <= '0;
         r_stage_x <= '0;
         r_stage_y <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         SUM_BIN   <= '0;
         C_OUT     <= 1'b0;
         X7        <= encode({BW{1'b0}});
         Y7        <= encode({BW{1'b0}});
         S7        <= encode({BW{1'b0}});
      end else begin
         DONE <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_x     <= X;
                  r_y     <= Y;
                  r_sum   <= {1'b0, X} + {1'b0, Y} + {{W{1'b0}}, C_IN};
                  r_sel   <= 2'd0;
                  BUSY    <= 1'b1;
                  r_state <= S_LOAD;
               end else begin
                  BUSY    <= 1'b0;
               end
            end
            S_LOAD: begin
               r_sh    <= {{BW{1'b0}}, w_val};
               r_cnt   <= '0;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_sh  <= w_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(W)) begin
                  case (r_sel)
                     2'd0: begin
                        r_stage_x <= w_next_bcd;
                        r_sel     <= 2'd1;
                        r_state   <= S_LOAD;
                     end
                     2'd1: begin
                        r_stage_y <= w_next_bcd;
                        r_sel     <= 2'd2;
                        r_state   <= S_LOAD;
                     end
                     default: begin
                        X7      <= encode(r_stage_x);
                        Y7      <= encode(r_stage_y);
                        S7      <= encode(w_next_bcd);
                        SUM_BIN <= r_sum;
                        C_OUT   <= r_sum[W];
                        DONE    <= 1'b1;
                        r_state <= S_FIN;
                     end
                  endcase
               end
            end
            S_FIN: begin
               BUSY    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               BUSY    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
